// File: rtl/psram_pkg.sv
`timescale 1ns/1ps
// psram_pkg: opcodes and responder state encoding shared by responder and initiator.
// Latency: none (constants and types only).
// Backpressure: none.
package psram_pkg;

  // Command opcodes
  localparam logic [7:0] OP_RSTEN  = 8'h66;  // reset enable
  localparam logic [7:0] OP_RST    = 8'h99;  // reset (only after RSTEN)
  localparam logic [7:0] OP_QPI_EN = 8'h35;  // enter QPI command width
  localparam logic [7:0] OP_QPI_EX = 8'hF5;  // exit QPI command width
  localparam logic [7:0] OP_QREAD  = 8'hEB;  // quad read
  localparam logic [7:0] OP_QWRITE = 8'h38;  // quad write

  // The address is always six nibbles (24 bits) on the wire
  localparam int ADDR_NIBBLES = 6;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    WAIT,
    WDATA,
    RDATA,
    IGNORE
  } state_t;

endpackage

// File: rtl/psram_resp_sync.sv
`timescale 1ns/1ps
// psram_resp_sync: 2-FF synchronizers for CE/SCLK/SIO plus SCLK edge strobes.
// Latency: 2 clk from pad to ce_n_s/sio_s; edge strobes valid the cycle the synced clock changes.
// Backpressure: none; free-running sampler, strobes are single-cycle.
// Ports: clk, rst_n            - system clock, async active-low reset
//        mem_ce_n, mem_clk, sio_in - raw pad inputs
//        ce_n_s, sio_s          - synchronized chip enable and data
//        sclk_rise, sclk_fall   - one-clk strobes on synchronized mem_clk edges
module psram_resp_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mem_ce_n,
  input  logic       mem_clk,
  input  logic [3:0] sio_in,
  output logic       ce_n_s,
  output logic       sclk_rise,
  output logic       sclk_fall,
  output logic [3:0] sio_s
);

  logic       ce_m;
  logic       clk_m;
  logic       clk_s;
  logic       clk_q;
  logic [3:0] sio_m;

  // Data and clock go through the same depth, so sio_s lines up with the
  // mem_clk level seen in clk_s when the rise strobe fires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ce_m   <= 1'b1;
      ce_n_s <= 1'b1;
      clk_m  <= 1'b0;
      clk_s  <= 1'b0;
      clk_q  <= 1'b0;
      sio_m  <= 4'h0;
      sio_s  <= 4'h0;
    end else begin
      ce_m   <= mem_ce_n;
      ce_n_s <= ce_m;
      clk_m  <= mem_clk;
      clk_s  <= clk_m;
      clk_q  <= clk_s;
      sio_m  <= sio_in;
      sio_s  <= sio_m;
    end
  end

  assign sclk_rise = clk_s & ~clk_q;
  assign sclk_fall = ~clk_s & clk_q;

endmodule

// File: rtl/psram_responder.sv
`timescale 1ns/1ps
// psram_responder: PSRAM target model - SPI/QPI command decode, quad read/write to an internal byte array.
// Latency: read nibble appears 1 clk after the synced mem_clk falling edge that drives it.
// Backpressure: none; the initiator paces everything with mem_clk, CE high aborts within 1 clk of sync.
// Ports: clk, rst_n       - system clock (>= 4x mem_clk), async active-low reset
//        mem_ce_n, mem_clk, sio_in - initiator pins as seen at the pads
//        sio_out, sio_oe  - read nibble and its pad enable (only in RDATA)
//        qpi_mode         - 1 when the command phase is 4 bits per mem_clk
//        rst_done         - one-clk pulse when an RSTEN/RST pair completes
// Build option: define PSRAM_RESP_QPI_EN to enable 0x35/0xF5 QPI entry/exit;
//               otherwise those opcodes are unknown and qpi_mode stays 0.
module psram_responder #(
  parameter int ADDR_BITS   = 8,
  parameter int WAIT_CYCLES = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mem_ce_n,
  input  logic       mem_clk,
  input  logic [3:0] sio_in,
  output logic [3:0] sio_out,
  output logic       sio_oe,
  output logic       qpi_mode,
  output logic       rst_done
);

  import psram_pkg::*;

  localparam int         DEPTH     = 1 << ADDR_BITS;
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_CYCLES - 1);
  localparam logic [7:0] ADDR_LAST = 8'(ADDR_NIBBLES - 1);

  state_t state;
  state_t state_d;

  logic                 ce_n_s;
  logic                 sclk_rise;
  logic                 sclk_fall;
  logic [3:0]           sio_s;

  logic [7:0]           cnt;       // edges seen in the current state
  logic [6:0]           op_sh;     // opcode bits collected so far
  logic [7:0]           op_nxt;    // opcode including the bits on this edge
  logic                 op_last;   // this edge completes the opcode
  logic [ADDR_BITS-1:0] addr;
  logic                 is_read;
  logic                 rsten;
  logic                 rst_pend;  // RST accepted, fires when CE rises
  logic                 ce_armed;  // CE has been seen high since reset
  logic                 hi_vld;    // write high nibble captured
  logic [3:0]           hi_nib;
  logic                 nib_lo;    // next read drive is the low nibble

  logic [7:0]           mem [DEPTH];
  logic                 mem_we;
  logic [7:0]           mem_rd;

  psram_resp_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_ce_n  (mem_ce_n),
    .mem_clk   (mem_clk),
    .sio_in    (sio_in),
    .ce_n_s    (ce_n_s),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .sio_s     (sio_s)
  );

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    op_nxt  = qpi_mode ? {op_sh[3:0], sio_s} : {op_sh, sio_s[0]};
    op_last = qpi_mode ? (cnt == 8'd1) : (cnt == 8'd7);
    if (ce_n_s) begin
      state_d = IDLE;
    end else begin
      case (state)
        // ce_armed keeps a transfer that was already running when rst_n
        // released from being picked up half-way through.
        IDLE:  if (ce_armed) state_d = CMD;
        CMD:   if (sclk_rise && op_last) begin
                 if (op_nxt == OP_QREAD || op_nxt == OP_QWRITE) state_d = ADDR;
                 else                                            state_d = IGNORE;
               end
        ADDR:  if (sclk_rise && cnt == ADDR_LAST) begin
                 if (!is_read)              state_d = WDATA;
                 else if (WAIT_CYCLES == 0) state_d = RDATA;
                 else                       state_d = WAIT;
               end
        WAIT:  if (sclk_rise && cnt == WAIT_LAST) state_d = RDATA;
        default: ;
      endcase
    end
  end

  assign sio_oe = (state == RDATA);

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= 8'd0;
      op_sh    <= 7'd0;
      addr     <= '0;
      is_read  <= 1'b0;
      rsten    <= 1'b0;
      rst_pend <= 1'b0;
      ce_armed <= 1'b0;
      hi_vld   <= 1'b0;
      hi_nib   <= 4'h0;
      nib_lo   <= 1'b0;
      rst_done <= 1'b0;
      sio_out  <= 4'h0;
`ifdef PSRAM_RESP_QPI_EN
      qpi_mode <= 1'b0;
`endif
    end else begin
      rst_done <= 1'b0;

      if (state_d != state) cnt <= 8'd0;
      else if (sclk_rise)   cnt <= cnt + 8'd1;

      if (ce_n_s) begin
        ce_armed <= 1'b1;
        hi_vld   <= 1'b0;   // a lone write high nibble is dropped here
        nib_lo   <= 1'b0;
        if (rst_pend) begin
          rst_pend <= 1'b0;
          rst_done <= 1'b1;
`ifdef PSRAM_RESP_QPI_EN
          qpi_mode <= 1'b0;
`endif
        end
      end else begin
        case (state)
          CMD: if (sclk_rise) begin
            op_sh <= op_nxt[6:0];
            if (op_last) begin
              is_read <= (op_nxt == OP_QREAD);
              // Any opcode other than RSTEN consumes/clears the enable.
              rsten   <= (op_nxt == OP_RSTEN);
              if (op_nxt == OP_RST && rsten) rst_pend <= 1'b1;
`ifdef PSRAM_RESP_QPI_EN
              if (op_nxt == OP_QPI_EN)                  qpi_mode <= 1'b1;
              else if (op_nxt == OP_QPI_EX && qpi_mode) qpi_mode <= 1'b0;
`endif
            end
          end
          ADDR: if (sclk_rise) begin
            // Only the low ADDR_BITS of the 24-bit address survive the shift.
            addr <= ADDR_BITS'({addr, sio_s});
          end
          WDATA: if (sclk_rise) begin
            if (hi_vld) begin
              hi_vld <= 1'b0;
              addr   <= addr + ADDR_BITS'(1);
            end else begin
              hi_vld <= 1'b1;
              hi_nib <= sio_s;
            end
          end
          RDATA: if (sclk_fall) begin
            nib_lo <= ~nib_lo;
            if (nib_lo) addr <= addr + ADDR_BITS'(1);
          end
          default: ;
        endcase
      end

      // Output nibble is zero whenever the pad is not being driven.
      if (state_d != RDATA)
        sio_out <= 4'h0;
      else if (state == RDATA && sclk_fall)
        sio_out <= nib_lo ? mem_rd[3:0] : mem_rd[7:4];
    end
  end

`ifndef PSRAM_RESP_QPI_EN
  assign qpi_mode = 1'b0;
`endif

  // ---------------------------------------------------------------- memory
  // Not reset: contents survive both rst_n and the RST command.
  assign mem_we = !ce_n_s && (state == WDATA) && sclk_rise && hi_vld;
  assign mem_rd = mem[addr];

  always_ff @(posedge clk) begin
    if (mem_we) mem[addr] <= {hi_nib, sio_s};
  end

endmodule

// File: tb/tb_psram_responder.sv
`timescale 1ns/1ps
// tb_psram_responder: self-checking bench with a byte-array reference memory.
// Latency: each mem_clk phase is 4 clk; read nibbles are sampled at the end of the low phase.
// Backpressure: none; the bench is the initiator and paces everything.
module tb_psram_responder;
  import psram_pkg::*;

  localparam int AB    = 8;
  localparam int DEPTH = 1 << AB;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       mem_ce_n = 1'b1;
  logic       mem_clk  = 1'b0;
  logic [3:0] sio_in   = 4'h0;
  logic [3:0] sio_out;
  logic       sio_oe;
  logic       qpi_mode;
  logic       rst_done;

  psram_responder #(.ADDR_BITS(AB), .WAIT_CYCLES(6)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mem_ce_n (mem_ce_n),
    .mem_clk  (mem_clk),
    .sio_in   (sio_in),
    .sio_out  (sio_out),
    .sio_oe   (sio_oe),
    .qpi_mode (qpi_mode),
    .rst_done (rst_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int pulses   = 0;

  always @(posedge clk) if (rst_done) pulses <= pulses + 1;

  // Reference model
  logic [7:0] mmem [DEPTH];
  logic [7:0] wbuf [DEPTH];
  bit         m_qpi = 1'b0;

  logic [3:0] smp_dat;
  logic       smp_oe;

  typedef struct packed {
    logic [2:0][7:0] ops;   // sent [2] first
    logic [7:0]      exp;   // expected rst_done pulses
  } rst_vec_t;

  rst_vec_t rv [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // One mem_clk period; sio_out/sio_oe captured just before the rising edge.
  task automatic mclk(input logic [3:0] d);
    sio_in = d;
    repeat (4) @(posedge clk);
    #1;
    smp_dat = sio_out;
    smp_oe  = sio_oe;
    mem_clk = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    mem_clk = 1'b0;
  endtask

  task automatic ce_lo();
    mem_ce_n = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic ce_hi();
    mem_ce_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] op);
    if (m_qpi) begin
      mclk(op[7:4]);
      mclk(op[3:0]);
    end else begin
      for (int i = 7; i >= 0; i--) mclk({3'b000, op[i]});
    end
  endtask

  task automatic send_addr(input logic [23:0] a);
    for (int i = 5; i >= 0; i--) mclk(a[i*4 +: 4]);
  endtask

  task automatic send_frame(input logic [7:0] op);
    ce_lo();
    send_cmd(op);
    ce_hi();
  endtask

  task automatic do_write(input logic [23:0] a, input int n);
    ce_lo();
    send_cmd(OP_QWRITE);
    send_addr(a);
    for (int i = 0; i < n; i++) begin
      mclk(wbuf[i][7:4]);
      mclk(wbuf[i][3:0]);
      mmem[AB'(a + 24'(i))] = wbuf[i];
    end
    ce_hi();
  endtask

  task automatic start_read(input logic [23:0] a);
    ce_lo();
    send_cmd(OP_QREAD);
    send_addr(a);
    for (int w = 0; w < 6; w++) mclk(4'h0);
    chk("rd_wait_oe", 32'(smp_oe), 32'd0);
  endtask

  task automatic do_read(input logic [23:0] a, input int n, input string tag);
    logic [3:0] hi;
    start_read(a);
    for (int i = 0; i < n; i++) begin
      mclk(4'h0);
      hi = smp_dat;
      if (i == 0) chk("rd_data_oe", 32'(smp_oe), 32'd1);
      mclk(4'h0);
      chk(tag, 32'({hi, smp_dat}), 32'(mmem[AB'(a + 24'(i))]));
    end
    ce_hi();
    chk("rd_end_idle", 32'({sio_oe, sio_out}), 32'd0);
  endtask

  initial begin
    #(800_000);
    $display("FAIL watchdog: run did not finish, %0d/%0d checks passed so far", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    int base;

    rv[0] = '{ops: {8'h66, 8'h99, 8'h00}, exp: 8'd1};
    rv[1] = '{ops: {8'hAA, 8'h99, 8'h00}, exp: 8'd0};
    rv[2] = '{ops: {8'h66, 8'h12, 8'h99}, exp: 8'd0};
    rv[3] = '{ops: {8'h66, 8'h66, 8'h99}, exp: 8'd1};
    rv[4] = '{ops: {8'h66, 8'h99, 8'h99}, exp: 8'd1};
    rv[5] = '{ops: {8'h99, 8'h66, 8'h00}, exp: 8'd0};

    // Reset state
    #1;
    chk("rst_outputs", 32'({sio_oe, sio_out, qpi_mode, rst_done}), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_outputs", 32'({sio_oe, sio_out, qpi_mode, rst_done}), 32'd0);

    // Preload the whole array so every later read has a known value
    for (int i = 0; i < DEPTH; i++) wbuf[i] = 8'($urandom);
    do_write(24'h000000, DEPTH);

    // SPI write A5,3C at 0x10 then quad read back
    wbuf[0] = 8'hA5;
    wbuf[1] = 8'h3C;
    do_write(24'h000010, 2);
    do_read(24'h000010, 2, "rd_a53c");

    // Address wrap at the top of the array
    wbuf[0] = 8'h11;
    wbuf[1] = 8'h22;
    do_write(24'h0000FF, 2);
    do_read(24'h0000FF, 2, "rd_wrap");
    do_read(24'h000000, 1, "rd_wrap0");

    // RSTEN/RST sequences
    for (int v = 0; v < 6; v++) begin
      send_frame(8'h00);              // leaves the enable cleared
      base = pulses;
      for (int j = 2; j >= 0; j--) send_frame(rv[v].ops[j]);
      chk($sformatf("rst_vec%0d_pulses", v), 32'(pulses - base), 32'(rv[v].exp));
    end

    // Write aborted during the address phase
    ce_lo();
    send_cmd(OP_QWRITE);
    for (int i = 0; i < 3; i++) mclk(4'hF);
    mem_ce_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_addr_oe", 32'({sio_oe, sio_out}), 32'd0);
    ce_hi();

    // Three data nibbles: first byte lands, lone high nibble is dropped
    ce_lo();
    send_cmd(OP_QWRITE);
    send_addr(24'h000040);
    mclk(4'h9);
    mclk(4'h6);
    mclk(4'hE);
    mmem[8'h40] = 8'h96;
    mem_ce_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_wdata_oe", 32'({sio_oe, sio_out}), 32'd0);
    ce_hi();
    do_read(24'h000040, 2, "rd_partial");

    // Read aborted mid-data
    start_read(24'h000010);
    mclk(4'h0);
    mclk(4'h0);
    mem_ce_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_rd_oe", 32'({sio_oe, sio_out}), 32'd0);
    ce_hi();
    do_read(24'h000010, 2, "rd_after_abort");

    // Randomized traffic against the model
    for (int it = 0; it < 24; it++) begin
      logic [23:0] a;
      int          n;
      a = 24'($urandom);
      n = $urandom_range(1, 4);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
        do_write(a, n);
      end else begin
        do_read(a, n, "rd_rand");
      end
    end

`ifdef PSRAM_RESP_QPI_EN
    send_frame(OP_QPI_EN);
    m_qpi = 1'b1;
    chk("qpi_enter", 32'(qpi_mode), 32'd1);
    do_read(24'h000010, 2, "rd_qpi");
    wbuf[0] = 8'h5A;
    wbuf[1] = 8'hC3;
    do_write(24'h000080, 2);
    do_read(24'h000080, 2, "rd_qpi_wr");
    send_frame(OP_QPI_EX);
    m_qpi = 1'b0;
    chk("qpi_exit", 32'(qpi_mode), 32'd0);
    // RST issued in QPI width drops back to SPI
    send_frame(OP_QPI_EN);
    m_qpi = 1'b1;
    base = pulses;
    send_frame(OP_RSTEN);
    send_frame(OP_RST);
    m_qpi = 1'b0;
    chk("qpi_rst_mode", 32'(qpi_mode), 32'd0);
    chk("qpi_rst_pulse", 32'(pulses - base), 32'd1);
    send_frame(OP_QPI_EN);
    m_qpi = 1'b1;
    chk("qpi_reenter", 32'(qpi_mode), 32'd1);
`else
    send_frame(OP_QPI_EN);
    chk("qpi_disabled_35", 32'(qpi_mode), 32'd0);
    send_frame(OP_QPI_EX);
    chk("qpi_disabled_f5", 32'(qpi_mode), 32'd0);
`endif

    // rst_n asserted mid-read
    start_read(24'h000010);
    mclk(4'h0);
    chk("rstmid_oe_before", 32'(smp_oe), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_outputs", 32'({sio_oe, sio_out, qpi_mode}), 32'd0);
    m_qpi = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    // CE still low from before reset: the responder must stay idle
    for (int i = 0; i < 3; i++) begin
      mclk(4'h0);
      chk("rstrel_idle", 32'({smp_oe, smp_dat}), 32'd0);
    end
    ce_hi();
    do_read(24'h000010, 2, "rd_after_rst");
    do_read(24'h000040, 2, "rd_after_rst2");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/psram_responder.md
PSRAM_RESPONDER -- requirements
Module: psram_responder

Interface
REQ-001 Parameter ADDR_BITS, default 8, sets the internal memory depth to 2^ADDR_BITS bytes; only address bits [ADDR_BITS-1:0] are used.
REQ-002 Parameter WAIT_CYCLES, default 6, sets the number of mem_clk wait cycles between address and read data for 0xEB.
REQ-003 clk  input  1  system clock; all logic on posedge clk; must run at least 4x the mem_clk frequency.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 mem_ce_n  input  1  chip enable from initiator, active-low.
REQ-006 mem_clk  input  1  serial clock from initiator; idles low.
REQ-007 sio_in  input  4  SIO[3:0] as seen at the pads.
REQ-008 sio_out  output  4  read-data nibble driven toward the initiator.
REQ-009 sio_oe  output  1  pad output enable for sio_out, active-high.
REQ-010 qpi_mode  output  1  1 = command phase is 4 bits per mem_clk.
REQ-011 rst_done  output  1  one-clk pulse when a valid RSTEN/RST sequence completes.

Function
REQ-012 mem_ce_n, mem_clk and sio_in SHALL pass through a 2-FF synchronizer; the sample edge is a rising edge of synchronized mem_clk, and the drive edge is a falling edge.
REQ-013 States: IDLE, CMD, ADDR, WAIT, WDATA, RDATA, IGNORE; a synchronized mem_ce_n low in IDLE SHALL enter CMD.
REQ-014 CMD SHALL shift in 8 opcode bits MSB-first: 1 bit/edge from sio_in[0] when qpi_mode=0, 4 bits/edge when qpi_mode=1.
REQ-015 Opcode 0xEB (quad read) or 0x38 (quad write) SHALL go to ADDR and accept 6 nibbles (24-bit address, MSB-first).
REQ-016 After ADDR, 0x38 SHALL go to WDATA; 0xEB SHALL go to WAIT for WAIT_CYCLES sample edges, then to RDATA.
REQ-017 WDATA: each pair of nibbles (high first) SHALL write one byte at the current address, then increment the address.
REQ-018 WDATA: a lone high nibble at CE deassertion SHALL be discarded.
REQ-019 RDATA: the high nibble of mem[addr] SHALL appear on sio_out 1 clk after the first drive edge following WAIT; the low nibble follows on the next drive edge; the address then increments.
REQ-020 The address SHALL wrap from 2^ADDR_BITS-1 to 0.
REQ-021 sio_oe SHALL be 1 only in RDATA; otherwise sio_oe=0 and sio_out=0.
REQ-022 Opcode 0x66 sets an rsten flag.
REQ-023 Opcode 0x99 with rsten set SHALL clear qpi_mode and pulse rst_done on the cycle CE rises.
REQ-024 Any other opcode after 0x66 SHALL clear rsten; 0x99 without rsten SHALL be ignored.
REQ-025 Unknown opcodes SHALL go to IGNORE until CE rises.
REQ-026 Synchronized mem_ce_n high in any state SHALL return to IDLE within 1 clk, abort the transfer, and clear sio_oe.
REQ-027 Memory contents SHALL survive RST commands and rst_n.

Reset
REQ-028 rst_n low SHALL asynchronously force: state=IDLE, qpi_mode=0, rsten=0, sio_oe=0, sio_out=0, rst_done=0, synchronizer flops = idle values (ce_n=1, clk=0).
REQ-029 Release of rst_n mid-transfer SHALL wait in IDLE for a fresh CE falling edge.

Configuration
REQ-030 With macro PSRAM_RESP_QPI_EN defined, opcode 0x35 SHALL set qpi_mode and opcode 0xF5 (received in QPI width) SHALL clear it.
REQ-031 Without PSRAM_RESP_QPI_EN, 0x35/0xF5 SHALL be treated as unknown opcodes and qpi_mode SHALL be tied to 0.

Structure
REQ-032 Shared package psram_pkg SHALL hold the opcode constants (0x66, 0x99, 0x35, 0xF5, 0xEB, 0x38) and the state encodings, for reuse by the initiator side.
REQ-033 The synchronizer and edge detector SHALL be sub-module psram_resp_sync (outputs: ce_n_s, sclk_rise, sclk_fall, sio_s[3:0]).
REQ-034 The memory SHALL be an inferred reg array, single port.

Verification
REQ-035 SPI 0x38, addr 0x000010, data 0xA5,0x3C; then SPI 0xEB at the same address -> after 6 wait edges, sio_out = A,5,3,C and sio_oe=1 only during data.
REQ-036 0x66, CE high, 0x99, CE high -> rst_done pulses once; 0x99 alone -> no pulse.
REQ-037 With PSRAM_RESP_QPI_EN: 0x35 -> qpi_mode=1; next command 0xEB takes 2 edges; 0xF5 -> qpi_mode=0.
REQ-038 Write 0x11,0x22 starting at 0x0000FF (ADDR_BITS=8) -> mem[0xFF]=0x11, mem[0x00]=0x22.
REQ-039 CE raised after 3 nibbles of a write, and separately mid-read -> no memory change, sio_oe=0 within 3 clk.
REQ-040 rst_n asserted mid-RDATA with qpi_mode=1 -> sio_oe=0 and qpi_mode=0 immediately; memory is intact on re-read.
